decode_scan_n: RTL and testbench

Parametrised, registered n-to-2^n one-hot decoder and the successor to the fixed 4-to-16 enable decoder. It has two modes. In direct mode it decodes an external select. In scan mode it walks its own index from 0 to a runtime limit, holding each index for a fixed number of cycles. The block drives digit-select and row-select lines on the board, for example for multiplexed seven-segment displays and LED matrices.

---
 rtl/decode_scan_n.sv | 144 ++++++++++++++
 tb/tb_decode_scan_n.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_scan_n.sv
// rtl/decode_scan_n.sv - registered n-to-2^n one-hot decoder with direct and auto-scan modes
//
// Purpose:
//   Drives digit-select or row-select lines, such as those of a multiplexed display.
//   In direct mode the block decodes the external select x.
//   In scan mode it walks its own index from 0 up to last.
//   It holds each index for DWELL cycles.
//   All outputs are registered.
//
// Parameters:
//   SEL_W  select width (1..5); output width is 2**SEL_W
//   DWELL  cycles each index is held in scan mode (>= 1)
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   en    in   block enable; 0 forces the outputs inactive
//   mode  in   0 = direct decode of x, 1 = auto-scan
//   x     in   select input (direct mode)
//   last  in   scan wrap point; the index runs 0..last
//   y     out  one-hot decode of idx
//   idx   out  current index
//   step  out  one-cycle pulse when idx advances in scan mode
//   wrap  out  one-cycle pulse when idx returns to 0 in scan mode
//
// Configuration:
//   DECODE_ACTLOW_EN  when defined, y is active-low.
//                     y is all ones in reset and whenever the block is inactive.
module decode_scan_n #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        x,
  input  logic [SEL_W-1:0]        last,
  output logic [(1<<SEL_W)-1:0]   y,
  output logic [SEL_W-1:0]        idx,
  output logic                    step,
  output logic                    wrap
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

`ifdef DECODE_ACTLOW_EN
  localparam logic [OUT_W-1:0] Y_OFF = '1;
`else
  localparam logic [OUT_W-1:0] Y_OFF = '0;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [OUT_W-1:0] onehot;

  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = '0;
    idx_d   = '0;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    onehot  = '0;
    y_d     = Y_OFF;

    if (en) begin
      state_d = mode ? ST_SCAN : ST_DIRECT;
    end

    case (state_d)
      ST_DIRECT: begin
        idx_d = x;
      end
      ST_SCAN: begin
        // Entering scan restarts at index 0 with a fresh dwell, without a pulse.
        if (state_q != ST_SCAN) begin
          idx_d = '0;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          step_d = 1'b1;
          // ">=" rather than "==": if last shrank below idx, wrap at once
          // instead of counting up through the top of the range.
          if (idx_q >= last) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          idx_d = idx_q;
        end
      end
      default: begin
        idx_d = '0;
      end
    endcase

    onehot[idx_d] = 1'b1;
    if (state_d != ST_IDLE) begin
`ifdef DECODE_ACTLOW_EN
      y_d = ~onehot;
`else
      y_d = onehot;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      y_q     <= Y_OFF;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decode_scan_n.sv
// tb/tb_decode_scan_n.sv - self-checking bench for decode_scan_n (SEL_W=3/DWELL=4 and SEL_W=4/DWELL=1)
module tb_decode_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, mode;
  logic [2:0]  x_a, last_a, idx_a;
  logic [7:0]  y_a;
  logic        step_a, wrap_a;
  logic [3:0]  x_b, last_b, idx_b;
  logic [15:0] y_b;
  logic        step_b, wrap_b;

  decode_scan_n #(.SEL_W(3), .DWELL(4)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .x(x_a), .last(last_a),
    .y(y_a), .idx(idx_a), .step(step_a), .wrap(wrap_a)
  );

  decode_scan_n #(.SEL_W(4), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .x(x_b), .last(last_b),
    .y(y_b), .idx(idx_b), .step(step_b), .wrap(wrap_b)
  );

  // Expected y values are stored active-high; polarity is applied at compare time.
  typedef struct {
    string       name;
    logic [7:0]  ya;
    logic [2:0]  ia;
    logic        sa, wa;
    logic [15:0] yb;
    logic [3:0]  ib;
    logic        sb, wb;
  } exp_t;

  typedef struct {
    logic        en, mode;
    logic [2:0]  xa;
    logic [3:0]  xb;
    logic [7:0]  ya;
    logic [2:0]  ia;
    logic [15:0] yb;
    logic [3:0]  ib;
  } vec_t;

  exp_t sb_q[$];
  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [7:0] pol8(logic [7:0] v);
`ifdef DECODE_ACTLOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic logic [15:0] pol16(logic [15:0] v);
`ifdef DECODE_ACTLOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk(string name, string sig, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0h expected %0h", name, sig, act, exp);
    end
  endtask

  // Push the expectation for the coming edge, then pop and compare once the DUT has updated.
  task automatic tick(exp_t e);
    exp_t g;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      g = sb_q.pop_front();
      chk(g.name, "y_a",    32'(y_a),    32'(pol8(g.ya)));
      chk(g.name, "idx_a",  32'(idx_a),  32'(g.ia));
      chk(g.name, "step_a", 32'(step_a), 32'(g.sa));
      chk(g.name, "wrap_a", 32'(wrap_a), 32'(g.wa));
      chk(g.name, "y_b",    32'(y_b),    32'(pol16(g.yb)));
      chk(g.name, "idx_b",  32'(idx_b),  32'(g.ib));
      chk(g.name, "step_b", 32'(step_b), 32'(g.sb));
      chk(g.name, "wrap_b", 32'(wrap_b), 32'(g.wb));
    end
  endtask

  function automatic exp_t mk(string n, bit act_a, int ia, bit sa, bit wa,
                              bit act_b, int ib, bit sb, bit wb);
    exp_t e;
    e.name = n;
    e.ya   = act_a ? (8'd1 << ia) : 8'd0;
    e.ia   = 3'(ia);
    e.sa   = sa;
    e.wa   = wa;
    e.yb   = act_b ? (16'd1 << ib) : 16'd0;
    e.ib   = 4'(ib);
    e.sb   = sb;
    e.wb   = wb;
    return e;
  endfunction

  // Expected scan outputs k cycles after entry, for a fixed last.
  function automatic void scan_exp(int k, int d, int l, output int i, output bit s, output bit w);
    i = (k / d) % (l + 1);
    s = (k > 0) && (k % d == 0);
    w = s && (i == 0);
  endfunction

  task automatic scan_run(string n, int k0, int k1, int la, int lb);
    int ia, ib;
    bit sa, wa, sb, wb;
    for (int k = k0; k <= k1; k++) begin
      scan_exp(k, 4, la, ia, sa, wa);
      scan_exp(k, 1, lb, ib, sb, wb);
      tick(mk(n, 1, ia, sa, wa, 1, ib, sb, wb));
    end
  endtask

  task automatic do_reset(string n);
    rst = 1'b1;
    tick(mk(n, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
  endtask

  initial begin
    int ia, ib;
    bit sa, wa;
    exp_t e;

    vt.push_back('{1'b1, 1'b0, 3'd0, 4'd0,  8'h01, 3'd0, 16'h0001, 4'd0});
    vt.push_back('{1'b1, 1'b0, 3'd7, 4'd15, 8'h80, 3'd7, 16'h8000, 4'd15});
    vt.push_back('{1'b0, 1'b0, 3'd5, 4'd5,  8'h00, 3'd0, 16'h0000, 4'd0});
    vt.push_back('{1'b1, 1'b0, 3'd2, 4'd9,  8'h04, 3'd2, 16'h0200, 4'd9});
    vt.push_back('{1'b0, 1'b1, 3'd5, 4'd5,  8'h00, 3'd0, 16'h0000, 4'd0});
    vt.push_back('{1'b1, 1'b0, 3'd5, 4'd10, 8'h20, 3'd5, 16'h0400, 4'd10});
    for (int i = 0; i < 16; i++) begin
      vt.push_back('{1'b1, 1'b0, 3'(i), 4'(i), 8'd1 << (i % 8), 3'(i % 8), 16'd1 << i, 4'(i)});
    end

    rst = 1'b1; en = 1'b0; mode = 1'b0;
    x_a = '0; x_b = '0; last_a = '0; last_b = '0;
    do_reset("reset");

    // Direct decode and enable from the vector table.
    foreach (vt[j]) begin
      en = vt[j].en; mode = vt[j].mode; x_a = vt[j].xa; x_b = vt[j].xb;
      e.name = $sformatf("vec%0d", j);
      e.ya = vt[j].ya; e.ia = vt[j].ia; e.sa = 1'b0; e.wa = 1'b0;
      e.yb = vt[j].yb; e.ib = vt[j].ib; e.sb = 1'b0; e.wb = 1'b0;
      tick(e);
    end

    // Scan with wrap: A runs 0..5 with a dwell of 4; B runs 0..7 with a dwell of 1.
    do_reset("reset_direct");
    last_a = 3'd5; last_b = 4'd7; en = 1'b1; mode = 1'b1;
    scan_run("scan", 0, 31, 5, 7);

    // Runtime shrink of last while A sits at idx 6; B scans with last=0.
    do_reset("reset_scan");
    last_a = 3'd7; last_b = 4'd0;
    scan_run("shrink_pre", 0, 24, 7, 0);
    last_a = 3'd2;
    for (int k = 25; k <= 44; k++) begin
      if (k < 28) begin
        ia = 6; sa = 0; wa = 0;
      end else if (k == 28) begin
        ia = 0; sa = 1; wa = 1;
      end else begin
        scan_exp(k - 28, 4, 2, ia, sa, wa);
      end
      tick(mk("shrink", 1, ia, sa, wa, 1, 0, 1, 1));
    end

    // Reset mid-dwell at idx 3.
    do_reset("reset2");
    last_a = 3'd5; last_b = 4'd7;
    scan_run("pre_rst", 0, 13, 5, 7);
    do_reset("rst_mid_dwell");

    // en=0 mid-scan, then re-entry from idle, then SCAN->DIRECT mid-dwell.
    scan_run("pre_dis", 0, 5, 5, 7);
    en = 1'b0;
    tick(mk("disable", 0, 0, 0, 0, 0, 0, 0, 0));
    en = 1'b1;
    scan_run("reenter", 0, 5, 5, 7);
    mode = 1'b0; x_a = 3'd3; x_b = 4'd9;
    tick(mk("to_direct", 1, 3, 0, 0, 1, 9, 0, 0));

    // Back to scan with last=0: idx stays 0 and every advance pulses step and wrap together.
    mode = 1'b1; last_a = 3'd0; last_b = 4'd0;
    scan_run("last0", 0, 12, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
